// File: rtl/axi_lite_pkg.sv
// Shared response codes, FSM state type and byte-merge helper for the
// AXI-Lite write responder.
package axi_lite_pkg;

   typedef enum logic [2:0] {
      IDLE,
      HAVE_AW,
      HAVE_W,
      HAVE_BOTH,
      RESP
   } state_t;

   localparam logic [1:0] OKAY   = 2'b00;
   localparam logic [1:0] SLVERR = 2'b10;
   localparam logic [1:0] DECERR = 2'b11;

   function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  strb);
      merge_bytes = old_val;
      for (int k = 0; k < 4; k++)
         if (strb[k]) merge_bytes[8*k +: 8] = new_val[8*k +: 8];
   endfunction

endpackage

// File: rtl/axi_lite_hold_reg.sv
// One-entry hold buffer: takes a beat when empty, keeps it until cleared.
module axi_lite_hold_reg #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_data,
   output logic             in_ready,
   input  logic             clear,
   output logic             full,
   output logic [WIDTH-1:0] data
);

   // Ready stays low throughout reset so nothing is taken while held.
   assign in_ready = ~full & ~rst;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         full <= 1'b0;
         data <= '0;
      end else begin
         if (clear) full <= 1'b0;
         if (in_valid && in_ready) begin
            full <= 1'b1;
            data <= in_data;
         end
      end
   end

endmodule

// File: rtl/axi_lite_write_responder.sv
// AXI-Lite write-only slave: buffers AW and W independently, commits into a
// small register window and returns OKAY/SLVERR/DECERR.
module axi_lite_write_responder
   import axi_lite_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
   parameter int          NUM_REGS  = 8
) (
   input  logic                     s_axi_aclk,
   input  logic                     s_axi_areset,
   input  logic [31:0]              s_axi_lite_awaddr,
   input  logic [2:0]               s_axi_lite_awprot,
   input  logic                     s_axi_lite_awvalid,
   output logic                     s_axi_lite_awready,
   input  logic [31:0]              s_axi_lite_wdata,
   input  logic [3:0]               s_axi_lite_wstrb,
   input  logic                     s_axi_lite_wvalid,
   output logic                     s_axi_lite_wready,
   output logic [1:0]               s_axi_lite_bresp,
   output logic                     s_axi_lite_bvalid,
   input  logic                     s_axi_lite_bready,
   output logic [NUM_REGS*32-1:0]   regs,
   output logic [31:0]              wr_count,
   output logic [15:0]              err_count
);

   localparam int IDX_W = $clog2(NUM_REGS);
   localparam int LO    = IDX_W + 2;

   state_t                      state, next_state;
   logic                        aw_full, w_full, aw_hs, w_hs, commit;
   logic [31:0]                 aw_addr;
   logic [35:0]                 w_buf;
   logic [1:0]                  resp_q, resp_d;
   logic [IDX_W-1:0]            idx;
   logic [NUM_REGS-1:0][31:0]   regs_q;
   logic                        unused_ok;

   assign unused_ok = ^s_axi_lite_awprot;

   axi_lite_hold_reg #(.WIDTH(32)) u_aw (
      .clk      (s_axi_aclk),
      .rst      (s_axi_areset),
      .in_valid (s_axi_lite_awvalid),
      .in_data  (s_axi_lite_awaddr),
      .in_ready (s_axi_lite_awready),
      .clear    (commit),
      .full     (aw_full),
      .data     (aw_addr)
   );

   axi_lite_hold_reg #(.WIDTH(36)) u_w (
      .clk      (s_axi_aclk),
      .rst      (s_axi_areset),
      .in_valid (s_axi_lite_wvalid),
      .in_data  ({s_axi_lite_wstrb, s_axi_lite_wdata}),
      .in_ready (s_axi_lite_wready),
      .clear    (commit),
      .full     (w_full),
      .data     (w_buf)
   );

   assign aw_hs = s_axi_lite_awvalid & s_axi_lite_awready;
   assign w_hs  = s_axi_lite_wvalid  & s_axi_lite_wready;

   function automatic state_t fill_state(input logic a, input logic w);
      case ({a, w})
         2'b11:   fill_state = HAVE_BOTH;
         2'b10:   fill_state = HAVE_AW;
         2'b01:   fill_state = HAVE_W;
         default: fill_state = IDLE;
      endcase
   endfunction

   always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
      if (s_axi_areset) state <= IDLE;
      else              state <= next_state;
   end

   // Buffer occupancy after this edge decides where we land, including
   // beats that arrived while the response was still pending.
   always_comb begin
      next_state = state;
      case (state)
         IDLE, HAVE_AW, HAVE_W:
            next_state = fill_state(aw_full | aw_hs, w_full | w_hs);
         HAVE_BOTH:
            next_state = RESP;
         RESP:
            if (s_axi_lite_bready) next_state = fill_state(aw_full | aw_hs, w_full | w_hs);
         default:
            next_state = IDLE;
      endcase
   end

   always_comb begin
      commit            = (state == HAVE_BOTH);
      s_axi_lite_bvalid = (state == RESP);
      s_axi_lite_bresp  = s_axi_lite_bvalid ? resp_q : OKAY;
   end

   always_comb begin
      idx = aw_addr[LO-1:2];
      if (aw_addr[31:LO] != BASE_ADDR[31:LO]) resp_d = DECERR;
      else if (aw_addr[1:0] != 2'b00)         resp_d = SLVERR;
      else                                    resp_d = OKAY;
   end

   always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
      if (s_axi_areset) begin
         regs_q    <= '0;
         resp_q    <= OKAY;
         wr_count  <= '0;
         err_count <= '0;
      end else if (commit) begin
         resp_q <= resp_d;
         if (resp_d == OKAY) begin
            regs_q[idx] <= merge_bytes(regs_q[idx], w_buf[31:0], w_buf[35:32]);
            wr_count    <= wr_count + 32'd1;
         end else if (err_count != 16'hFFFF) begin
            err_count <= err_count + 16'd1;
         end
      end
   end

   assign regs = regs_q;

endmodule

// File: tb/tb_axi_lite_write_responder.sv
// Directed bench with a transaction-level reference model checked every cycle.
module tb_axi_lite_write_responder;

   localparam logic [31:0] BASE = 32'h0000_0000;
   localparam int          NR   = 8;

   logic              clk = 1'b0;
   logic              rst;
   logic [31:0]       awaddr;
   logic [2:0]        awprot;
   logic              awvalid, awready;
   logic [31:0]       wdata;
   logic [3:0]        wstrb;
   logic              wvalid, wready;
   logic [1:0]        bresp;
   logic              bvalid, bready;
   logic [NR*32-1:0]  regs;
   logic [31:0]       wr_count;
   logic [15:0]       err_count;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   axi_lite_write_responder #(.BASE_ADDR(BASE), .NUM_REGS(NR)) dut (
      .s_axi_aclk         (clk),
      .s_axi_areset       (rst),
      .s_axi_lite_awaddr  (awaddr),
      .s_axi_lite_awprot  (awprot),
      .s_axi_lite_awvalid (awvalid),
      .s_axi_lite_awready (awready),
      .s_axi_lite_wdata   (wdata),
      .s_axi_lite_wstrb   (wstrb),
      .s_axi_lite_wvalid  (wvalid),
      .s_axi_lite_wready  (wready),
      .s_axi_lite_bresp   (bresp),
      .s_axi_lite_bvalid  (bvalid),
      .s_axi_lite_bready  (bready),
      .regs               (regs),
      .wr_count           (wr_count),
      .err_count          (err_count)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         if (failures <= 20) $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   // Reference model: one pending AW, one pending W, one outstanding response.
   logic                    m_aw_v, m_w_v, m_bv;
   logic [31:0]             m_aw, m_wd;
   logic [3:0]              m_ws;
   logic [1:0]              m_resp;
   logic [NR-1:0][31:0]     m_regs;
   logic [31:0]             m_wr;
   logic [15:0]             m_err;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_aw_v <= 0; m_w_v <= 0; m_bv <= 0; m_aw <= 0; m_wd <= 0; m_ws <= 0;
         m_resp <= 0; m_regs <= '0; m_wr <= 0; m_err <= 0;
      end else begin
         if (m_bv && bready) m_bv <= 0;
         if (m_aw_v && m_w_v && !m_bv) begin
            m_aw_v <= 0; m_w_v <= 0; m_bv <= 1;
            if (m_aw < BASE || m_aw >= BASE + NR * 4) begin
               m_resp <= 2'b11;
               if (m_err != 16'hFFFF) m_err <= m_err + 1;
            end else if (m_aw % 4 != 0) begin
               m_resp <= 2'b10;
               if (m_err != 16'hFFFF) m_err <= m_err + 1;
            end else begin
               m_resp <= 2'b00;
               m_wr   <= m_wr + 1;
               for (int k = 0; k < 4; k++)
                  if (m_ws[k]) m_regs[(m_aw - BASE) / 4][8*k +: 8] <= m_wd[8*k +: 8];
            end
         end
         if (awvalid && !m_aw_v) begin m_aw_v <= 1; m_aw <= awaddr; end
         if (wvalid && !m_w_v)   begin m_w_v  <= 1; m_wd <= wdata; m_ws <= wstrb; end
      end
   end

   always @(negedge clk) begin
      chk("awready",   32'(awready),   32'(!rst && !m_aw_v));
      chk("wready",    32'(wready),    32'(!rst && !m_w_v));
      chk("bvalid",    32'(bvalid),    32'(m_bv));
      chk("bresp",     32'(bresp),     32'(m_bv ? m_resp : 2'b00));
      chk("wr_count",  wr_count,       m_wr);
      chk("err_count", 32'(err_count), 32'(m_err));
      for (int i = 0; i < NR; i++)
         chk($sformatf("reg%0d", i), regs[32*i +: 32], m_regs[i]);
   end

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                     output logic [1:0] r);
      int n;
      awaddr = a; wdata = d; wstrb = s; awvalid = 1; wvalid = 1;
      n = 0;
      while (!(awready && wready) && n < 50) begin step; n++; end
      step;
      awvalid = 0; wvalid = 0;
      n = 0;
      while (!bvalid && n < 50) begin step; n++; end
      chk("wr_bvalid_seen", 32'(bvalid), 32'd1);
      r = bresp;
      step;
   endtask

   initial begin
      logic [1:0] r;
      int n, cyc;
      rst = 1; awaddr = 0; awprot = 0; awvalid = 0; wdata = 0; wstrb = 0;
      wvalid = 0; bready = 1;
      step; step;
      chk("rst_awready_low", 32'(awready), 32'd0);
      chk("rst_regs",        regs[31:0],   32'd0);
      rst = 0;
      step;
      chk("post_rst_awready", 32'(awready), 32'd1);

      // Same-cycle AW+W
      awaddr = 32'h04; wdata = 32'hDEADBEEF; wstrb = 4'hF; awvalid = 1; wvalid = 1;
      step;
      awvalid = 0; wvalid = 0;
      chk("s1_bvalid_early", 32'(bvalid), 32'd0);
      step;
      chk("s1_bvalid",   32'(bvalid),   32'd1);
      chk("s1_bresp",    32'(bresp),    32'd0);
      chk("s1_reg1",     regs[63:32],   32'hDEADBEEF);
      chk("s1_wr_count", wr_count,      32'd1);
      step;
      chk("s1_bvalid_drop", 32'(bvalid), 32'd0);

      // W first, AW three cycles later, partial strobes
      wr(32'h08, 32'hFFFF_FFFF, 4'hF, r);
      wdata = 32'h11223344; wstrb = 4'b0101; wvalid = 1;
      step;
      wvalid = 0;
      step; step;
      chk("s2_bvalid_wait", 32'(bvalid), 32'd0);
      awaddr = 32'h08; awvalid = 1;
      step;
      awvalid = 0;
      chk("s2_bvalid_early", 32'(bvalid), 32'd0);
      step;
      chk("s2_bvalid", 32'(bvalid),  32'd1);
      chk("s2_reg2",   regs[95:64],  32'hFF22FF44);
      step;

      // Errors
      wr(32'h06, 32'hAAAA_AAAA, 4'hF, r);
      chk("s3_slverr", 32'(r), 32'd2);
      wr(BASE + 32'h40, 32'hBBBB_BBBB, 4'hF, r);
      chk("s3_decerr", 32'(r), 32'd3);
      chk("s3_err_count", 32'(err_count), 32'd2);
      chk("s3_wr_count",  wr_count,       32'd3);
      chk("s3_reg1",      regs[63:32],    32'hDEADBEEF);

      // Back-pressure on B with a second transaction buffered
      bready = 0;
      awaddr = 32'h0C; wdata = 32'hA5A5A5A5; wstrb = 4'hF; awvalid = 1; wvalid = 1;
      step;
      awvalid = 0; wvalid = 0;
      step;
      chk("s4_bvalid1",   32'(bvalid), 32'd1);
      chk("s4_wr_count1", wr_count,    32'd4);
      awaddr = 32'h10; wdata = 32'h5A5A5A5A; awvalid = 1; wvalid = 1;
      step;
      awvalid = 0; wvalid = 0;
      for (int i = 0; i < 10; i++) begin
         chk("s4_hold_bvalid", 32'(bvalid),   32'd1);
         chk("s4_hold_bresp",  32'(bresp),    32'd0);
         chk("s4_hold_reg4",   regs[159:128], 32'd0);
         step;
      end
      bready = 1;
      step;
      chk("s4_gap_bvalid", 32'(bvalid),   32'd0);
      chk("s4_gap_reg4",   regs[159:128], 32'd0);
      step;
      chk("s4_bvalid2",   32'(bvalid),   32'd1);
      chk("s4_reg4",      regs[159:128], 32'h5A5A5A5A);
      chk("s4_wr_count2", wr_count,      32'd5);
      step;

      // Zero strobe and top register index
      wr(32'h00, 32'hFFFF_FFFF, 4'h0, r);
      chk("strb0_resp", 32'(r),      32'd0);
      chk("strb0_reg0", regs[31:0],  32'd0);
      wr(32'h1C, 32'h0BAD_F00D, 4'hF, r);
      chk("top_reg7",     regs[255:224], 32'h0BADF00D);
      chk("top_wr_count", wr_count,      32'd7);

      // Reset with AW buffered
      awaddr = 32'h14; awvalid = 1;
      step;
      awvalid = 0;
      chk("s5_aw_held", 32'(awready), 32'd0);
      rst = 1;
      #2;
      chk("s5_rst_awready", 32'(awready), 32'd0);
      chk("s5_rst_wready",  32'(wready),  32'd0);
      chk("s5_rst_reg1",    regs[63:32],  32'd0);
      chk("s5_rst_wr",      wr_count,     32'd0);
      step; step;
      rst = 0;
      #1;
      chk("s5_rel_awready", 32'(awready), 32'd1);
      for (int i = 0; i < 3; i++) begin
         step;
         chk("s5_no_bvalid", 32'(bvalid), 32'd0);
      end
      wr(32'h14, 32'h12345678, 4'hF, r);
      chk("s5_resp", 32'(r),          32'd0);
      chk("s5_reg5", regs[191:160],   32'h12345678);
      chk("s5_wr",   wr_count,        32'd1);

      // Error counter saturation
      awaddr = 32'h100; wdata = 0; wstrb = 4'hF; awvalid = 1; wvalid = 1;
      n = 0; cyc = 0;
      while (n < 65540 && cyc < 140000) begin
         step;
         cyc++;
         if (bvalid) n++;
      end
      chk("sat_resp_count", 32'(n), 32'd65540);
      awvalid = 0; wvalid = 0;
      step; step; step; step;
      chk("sat_err_count", 32'(err_count), 32'h0000FFFF);
      chk("sat_wr_count",  wr_count,       32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/axi_lite_write_responder.md
AXI_LITE_WRITE_RESPONDER -- requirements
Module: axi_lite_write_responder

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h0000_0000, meaning the 32-byte-aligned base of the register window.
REQ-002 SHALL have parameter NUM_REGS, default 8, meaning the number of 32-bit registers (power of two, 2..16).
REQ-003 SHALL have port s_axi_aclk  input  1  the single clock; all logic is rising-edge.
REQ-004 SHALL have port s_axi_areset  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have ports s_axi_lite_awaddr  input  32  write address; s_axi_lite_awprot  input  3  protection, ignored; s_axi_lite_awvalid  input  1; s_axi_lite_awready  output  1.
REQ-006 SHALL have ports s_axi_lite_wdata  input  32; s_axi_lite_wstrb  input  4  byte enables; s_axi_lite_wvalid  input  1; s_axi_lite_wready  output  1.
REQ-007 SHALL have ports s_axi_lite_bresp  output  2; s_axi_lite_bvalid  output  1; s_axi_lite_bready  input  1.
REQ-008 SHALL have ports regs  output  NUM_REGS*32  register contents, reg i at bits [32i+31:32i]; wr_count  output  32  count of OKAY writes; err_count  output  16  count of error writes.

Function
REQ-009 SHALL accept AW and W independently, each into a one-entry hold buffer; awready = AW buffer empty, wready = W buffer empty.
REQ-010 SHALL use FSM states IDLE, HAVE_AW, HAVE_W, HAVE_BOTH, RESP; IDLE->HAVE_AW/HAVE_W/HAVE_BOTH on the respective handshakes (same-cycle AW+W -> HAVE_BOTH).
REQ-011 SHALL commit in HAVE_BOTH on the next edge: update register/counters, load bresp, assert bvalid, clear both buffers, go to RESP.
REQ-012 SHALL make bvalid rise exactly one cycle after the later of the AW and W handshakes; register update visible in the same cycle as bvalid.
REQ-013 SHALL hold bvalid and bresp stable until bready; on the bvalid&bready edge drop bvalid and go to HAVE_AW/HAVE_W/HAVE_BOTH/IDLE per buffers filled during RESP.
REQ-014 SHALL keep accepting AW and W in RESP (buffers empty after commit), so the next transaction may buffer while a response is pending; no commit while bvalid is high.
REQ-015 SHALL decode: awaddr[31:5+log2(NUM_REGS/8)] must match BASE_ADDR, index = awaddr[log2(NUM_REGS)+1:2].
REQ-016 SHALL respond OKAY (2'b00) and write bytes where wstrb[k]=1 for an aligned in-window address; wstrb=4'b0000 is OKAY with no data change.
REQ-017 SHALL respond SLVERR (2'b10) when awaddr[1:0]!=0, DECERR (2'b11) when out of window (DECERR takes priority), with no register change.
REQ-018 SHALL increment wr_count on each OKAY commit, wrapping 32'hFFFF_FFFF->0; err_count on each error commit, saturating at 16'hFFFF.
REQ-019 SHALL drive bresp=2'b00 whenever bvalid is low.

Reset
REQ-020 SHALL, on s_axi_areset high at any time including mid-transaction, immediately force FSM=IDLE, buffers empty, awready=1 and wready=1 after release, bvalid=0, bresp=0, regs=0, wr_count=0, err_count=0.
REQ-021 SHALL discard any buffered or pending-response transaction on reset; no response is issued for it.
REQ-022 SHALL hold awready and wready low while s_axi_areset is high.

Structure
REQ-023 SHALL take resp codes (OKAY, SLVERR, DECERR) and the FSM state typedef from shared package axi_lite_pkg.
REQ-024 SHALL implement each hold buffer as sub-module axi_lite_hold_reg (parameterised width, valid/ready in, full flag, clear), instantiated for AW (32 bits) and W (36 bits).

Verification
REQ-025 SHALL cover: AW+W same cycle, addr 0x04, data 0xDEADBEEF, wstrb 4'hF, bready=1 -> bvalid next cycle, bresp 00, reg1=0xDEADBEEF, wr_count=1.
REQ-026 SHALL cover: W first, AW 3 cycles later, addr 0x08, wstrb 4'b0101, data 0x11223344 onto 0xFFFFFFFF -> reg2=0xFF22FF44, bvalid one cycle after AW handshake.
REQ-027 SHALL cover: addr 0x06 -> bresp 10; addr BASE_ADDR+0x40 -> bresp 11; regs unchanged, err_count=2.
REQ-028 SHALL cover: bready low 10 cycles with second AW+W issued -> bvalid/bresp stable, second commit only after first bready, second bvalid next cycle.
REQ-029 SHALL cover: s_axi_areset asserted while in HAVE_AW -> all outputs at reset values, no bvalid after release, next write completes normally.
REQ-030 SHALL cover: 65540 back-to-back DECERR writes -> err_count saturates at 0xFFFF.
